// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// timer_pkg: shared types and constants for the microwave timer setter.
// Revision: 1.0
// ============================================================================
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t           BCD_MAX           = 4'd9;
  localparam bcd_t           SEC_TENS_MAX      = 4'd5;
  localparam logic [7:0]     QUICK_SEC_DEFAULT = 8'h30;

endpackage
`default_nettype wire

// File: rtl/digit_shift_reg.sv
`default_nettype none
// ============================================================================
// digit_shift_reg: NDIG x 4-bit BCD entry buffer with shift-in, clear and
// parallel load; new digits enter digit0, the top digit falls off.
// Revision: 1.0
// ============================================================================
module digit_shift_reg
  import timer_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_clear,
  input  logic              i_shift,
  input  bcd_t              i_digit,
  input  logic              i_load,
  input  logic [4*NDIG-1:0] i_load_val,
  output logic [4*NDIG-1:0] o_digits
);

  localparam int BUF_W = 4 * NDIG;

  logic [BUF_W-1:0] r_digits;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_digits <= '0;
    end else if (i_clear) begin
      r_digits <= '0;
    end else if (i_load) begin
      r_digits <= i_load_val;
    end else if (i_shift) begin
      r_digits <= {r_digits[BUF_W-5:0], i_digit};
    end
  end

  assign o_digits = r_digits;

endmodule
`default_nettype wire

// File: rtl/timer_setter.sv
`default_nettype none
// ============================================================================
// timer_setter: collects keypad digits into an MM:SS BCD buffer, loads the
// countdown chain and gates its enable with the 1 Hz tick until zero/cancel.
// Optional feature macro: TIMER_QUICK_START_EN (quick start / +30 s).
// Revision: 1.0
// ============================================================================
module timer_setter
  import timer_pkg::*;
#(
  parameter int NDIG = 4
`ifdef TIMER_QUICK_START_EN
  ,
  parameter logic [7:0] QUICK_SEC = QUICK_SEC_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              start,
  input  logic              cancel,
  input  logic              tick_1hz,
  input  logic              timer_zero,
  output logic [4*NDIG-1:0] data,
  output logic              loadn,
  output logic              cnt_en,
  output logic              running,
  output logic              done,
  output logic              err
);

  localparam int BUF_W = 4 * NDIG;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [BUF_W-1:0] w_buf;
  logic [BUF_W-1:0] w_load_val;
  logic [BUF_W-1:0] r_data;
  logic             w_buf_clear;
  logic             w_buf_shift;
  logic             w_buf_load;
  logic             w_data_load;
  logic             w_err_nxt;
  logic             w_done_nxt;
  logic             r_run_first;
  logic             r_done;
  logic             r_err;
  logic             w_key_ok;
  bcd_t             w_sec_tens;

  assign w_key_ok   = key_valid && (key_code <= BCD_MAX);
  assign w_sec_tens = w_buf[7:4];

`ifdef TIMER_QUICK_START_EN
  localparam logic [BUF_W-1:0] QUICK_EXT = BUF_W'(QUICK_SEC);

  logic [BUF_W-1:0] w_sum;
  logic [4:0]       w_dsum;
  logic             w_carry;

  // Digit-serial BCD add; the seconds-tens digit wraps at 6, overflow saturates.
  always_comb begin
    w_sum   = '0;
    w_dsum  = '0;
    w_carry = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      w_dsum = {1'b0, w_buf[4*i +: 4]} + {1'b0, QUICK_EXT[4*i +: 4]} + {4'd0, w_carry};
      if (i == 1) begin
        w_carry = (w_dsum > {1'b0, SEC_TENS_MAX});
        if (w_carry) w_dsum = w_dsum - 5'd6;
      end else begin
        w_carry = (w_dsum > {1'b0, BCD_MAX});
        if (w_carry) w_dsum = w_dsum - 5'd10;
      end
      w_sum[4*i +: 4] = w_dsum[3:0];
    end
    if (w_carry) begin
      for (int i = 0; i < NDIG; i++) begin
        w_sum[4*i +: 4] = (i == 1) ? SEC_TENS_MAX : BCD_MAX;
      end
    end
  end
`endif

  digit_shift_reg #(
    .NDIG (NDIG)
  ) u_digit_shift_reg (
    .clk        (clk),
    .clr        (clr),
    .i_clear    (w_buf_clear),
    .i_shift    (w_buf_shift),
    .i_digit    (key_code),
    .i_load     (w_buf_load),
    .i_load_val (w_load_val),
    .o_digits   (w_buf)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_buf_clear = 1'b0;
    w_buf_shift = 1'b0;
    w_buf_load  = 1'b0;
    w_data_load = 1'b0;
    w_err_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_load_val  = w_buf;
    if (cancel) begin
      w_buf_clear = 1'b1;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
`ifdef TIMER_QUICK_START_EN
            w_load_val  = QUICK_EXT;
            w_buf_load  = 1'b1;
            w_data_load = 1'b1;
            w_state_nxt = ST_LOAD;
`else
            w_err_nxt   = 1'b1;
`endif
          end else if (w_key_ok) begin
            w_buf_shift = 1'b1;
            w_state_nxt = ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (start) begin
            if (w_sec_tens > SEC_TENS_MAX) begin
              w_err_nxt   = 1'b1;
            end else begin
              w_data_load = 1'b1;
              w_state_nxt = ST_LOAD;
            end
          end else if (w_key_ok) begin
            w_buf_shift = 1'b1;
          end
        end
        ST_LOAD: begin
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          // The zero flag is stale in the first RUN cycle, the load edge just updated it.
          if (!r_run_first && timer_zero) begin
            w_done_nxt  = 1'b1;
            w_buf_clear = 1'b1;
            w_state_nxt = ST_IDLE;
          end
`ifdef TIMER_QUICK_START_EN
          else if (start) begin
            w_load_val  = w_sum;
            w_buf_load  = 1'b1;
            w_data_load = 1'b1;
            w_state_nxt = ST_LOAD;
          end
`endif
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_data      <= '0;
      r_run_first <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_data_load) r_data <= w_load_val;
      r_run_first <= (r_state == ST_LOAD);
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign data    = r_data;
  assign loadn   = (r_state != ST_LOAD);
  assign running = (r_state == ST_RUN);
  assign cnt_en  = running & tick_1hz;
  assign done    = r_done;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_timer_setter.sv
`default_nettype none
// ============================================================================
// tb_timer_setter: randomized scoreboard bench for timer_setter against a
// seconds-based reference model of the keypad/start/cancel rules.
// Revision: 1.0
// ============================================================================
module tb_timer_setter;

  localparam int EV_LOAD = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_DONE = 2;

  localparam int P_IDLE  = 0;
  localparam int P_ENTRY = 1;
  localparam int P_LOAD  = 2;
  localparam int P_RUN   = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        timer_zero = 1'b0;
  logic [15:0] data;
  logic        loadn;
  logic        cnt_en;
  logic        running;
  logic        done;
  logic        err;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  mon_en  = 1'b0;

  ev_t         q[$];
  int          md[4];
  int          mphase = P_IDLE;
  bit          mfirst = 1'b0;
  logic [15:0] mdata = 16'h0;
  bit          exp_running = 1'b0;

  timer_setter dut (
    .clk        (clk),
    .clr        (clr),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .start      (start),
    .cancel     (cancel),
    .tick_1hz   (tick_1hz),
    .timer_zero (timer_zero),
    .data       (data),
    .loadn      (loadn),
    .cnt_en     (cnt_en),
    .running    (running),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] buf_val();
    logic [15:0] v = '0;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'(md[i]);
    return v;
  endfunction

  function automatic void buf_clear();
    for (int i = 0; i < 4; i++) md[i] = 0;
  endfunction

`ifdef TIMER_QUICK_START_EN
  // +30 s on a minutes/seconds value, saturating at 99:59.
  function automatic void quick_add();
    int mins = md[3] * 10 + md[2];
    int secs = md[1] * 10 + md[0];
    int tot  = mins * 60 + secs + 30;
    mins = tot / 60;
    secs = tot % 60;
    if (mins > 99) begin
      mins = 99;
      secs = 59;
    end
    md[3] = mins / 10; md[2] = mins % 10;
    md[1] = secs / 10; md[0] = secs % 10;
  endfunction
`endif

  function automatic void push(input int c, input int kind, input logic [15:0] d);
    ev_t e;
    e.cyc = c; e.kind = kind; e.data = d;
    q.push_back(e);
  endfunction

  function automatic void begin_load(input int c);
    mdata  = buf_val();
    mphase = P_LOAD;
    push(c, EV_LOAD, mdata);
  endfunction

  // One clock of stimulus; the model predicts what the DUT shows after the next edge.
  task automatic step(input bit kv, input logic [3:0] kc, input bit st, input bit cn,
                      input bit tk, input bit tz);
    int nc;
    @(negedge clk);
    key_valid = kv; key_code = kc; start = st; cancel = cn; tick_1hz = tk; timer_zero = tz;
    nc = cyc + 1;
    if (cn) begin
      buf_clear();
      mphase = P_IDLE;
    end else begin
      case (mphase)
        P_IDLE: begin
          if (st) begin
`ifdef TIMER_QUICK_START_EN
            buf_clear();
            md[1] = 3;
            begin_load(nc);
`else
            push(nc, EV_ERR, 16'h0);
`endif
          end else if (kv && kc <= 4'd9) begin
            md[3] = md[2]; md[2] = md[1]; md[1] = md[0]; md[0] = int'(kc);
            mphase = P_ENTRY;
          end
        end
        P_ENTRY: begin
          if (st) begin
            if (md[1] > 5) push(nc, EV_ERR, 16'h0);
            else begin_load(nc);
          end else if (kv && kc <= 4'd9) begin
            md[3] = md[2]; md[2] = md[1]; md[1] = md[0]; md[0] = int'(kc);
          end
        end
        P_LOAD: begin
          mphase = P_RUN;
          mfirst = 1'b1;
        end
        default: begin
          if (!mfirst && tz) begin
            push(nc, EV_DONE, 16'h0);
            buf_clear();
            mphase = P_IDLE;
          end
`ifdef TIMER_QUICK_START_EN
          else if (st) begin
            quick_add();
            begin_load(nc);
          end
`endif
          mfirst = 1'b0;
        end
      endcase
    end
    exp_running = (mphase == P_RUN);
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b1, k, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit tk, input bit tz);
    step(1'b0, 4'd0, 1'b0, 1'b0, tk, tz);
  endtask

  task automatic async_reset();
    @(negedge clk);
    key_valid = 1'b0; start = 1'b0; cancel = 1'b0; timer_zero = 1'b0; tick_1hz = 1'b1;
    #2 clr = 1'b1;
    #1;
    check("arst_running", {31'd0, running}, 32'd0);
    check("arst_loadn",   {31'd0, loadn},   32'd1);
    check("arst_cnt_en",  {31'd0, cnt_en},  32'd0);
    check("arst_done",    {31'd0, done},    32'd0);
    check("arst_err",     {31'd0, err},     32'd0);
    check("arst_data",    {16'd0, data},    32'd0);
    buf_clear();
    mphase = P_IDLE; mfirst = 1'b0; mdata = 16'h0; exp_running = 1'b0;
    @(negedge clk);
    clr = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic ev_check(input int kind, input logic [15:0] d);
    n_tests++;
    if (q.size() == 0 || q[0].cyc != cyc || q[0].kind != kind || q[0].data !== d) begin
      n_fail++;
      if (q.size() == 0)
        $display("FAIL event: got kind %0d data %h at cycle %0d, expected no event", kind, d, cyc);
      else
        $display("FAIL event: got kind %0d data %h at cycle %0d, expected kind %0d data %h at cycle %0d",
                 kind, d, cyc, q[0].kind, q[0].data, q[0].cyc);
    end else begin
      void'(q.pop_front());
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      check("running", {31'd0, running}, {31'd0, exp_running});
      check("cnt_en",  {31'd0, cnt_en},  {31'd0, exp_running & tick_1hz});
      check("data",    {16'd0, data},    {16'd0, mdata});
      if (!loadn) ev_check(EV_LOAD, data);
      if (err)    ev_check(EV_ERR, 16'h0);
      if (done)   ev_check(EV_DONE, 16'h0);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_event: got nothing, expected kind %0d data %h at cycle %0d",
                 q[0].kind, q[0].data, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    buf_clear();
    #3;
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_loadn",   {31'd0, loadn},   32'd1);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_err",     {31'd0, err},     32'd0);
    check("rst_data",    {16'd0, data},    32'd0);
    @(negedge clk);
    clr = 1'b0;
    mon_en = 1'b1;

    // 1,2,3 start -> load 0123, run, then count to zero
    key(4'd1); key(4'd2); key(4'd3);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    // five digits drop the first; cancel clears; start from IDLE
    for (int k = 1; k <= 5; k++) key(4'(k));
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    // 0,7,5 -> seconds tens of 7 rejected
    key(4'd0); key(4'd7); key(4'd5);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    // key+start together; then zero held from LOAD onward
    key(4'd4);
    step(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
    // cancel+start together; 0,4,5 start; +30s in RUN; cancel in RUN
    key(4'd2);
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    key(4'd0); key(4'd4); key(4'd5);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0); idle(1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0); idle(1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    // async reset while running
    key(4'd1); step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0); idle(1'b1, 1'b0);
    async_reset();

    for (int n = 0; n < 4000; n++) begin
      bit          kv, st, cn, tk, tz;
      logic [3:0]  kc;
      kv = ($urandom_range(0, 99) < 40);
      kc = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      st = ($urandom_range(0, 99) < 9);
      cn = ($urandom_range(0, 99) < 3);
      tk = ($urandom_range(0, 99) < 30);
      tz = ($urandom_range(0, 99) < 12);
      step(kv, kc, st, cn, tk, tz);
      if (n % 1000 == 999) async_reset();
    end

    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
